exc_ctrl: RTL and testbench

Exception/interrupt sequencer for the multicycle CPU's coprocessor 0. At each instruction boundary it arbitrates pending synchronous exceptions (syscall, break, teq), eret and external/timer interrupts. It then drives CP0's one-cycle `exception`/`eret`/`cause` controls, stalls the main control FSM, and redirects the PC to the CP0-supplied `exc_addr`. It sits between the main control FSM, CP0 and the PC register.

---
 rtl/exc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Exception/interrupt sequencer for coprocessor 0. At each
//               instruction boundary it picks the highest-priority pending
//               event (teq, break, syscall, eret, interrupt). It then strobes
//               CP0 for one cycle, waits one cycle for CP0's redirect address,
//               and loads the PC with that address. The main FSM is stalled
//               for the whole sequence.
//               Optional feature macro: EXC_CTRL_TIMER_EN adds a periodic
//               timer interrupt source of TIMER_PERIOD clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter logic [31:0] TIMER_PERIOD = 32'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_boundary,
    input  logic        sys_req,
    input  logic        brk_req,
    input  logic        teq_req,
    input  logic        eret_req,
    input  logic        intr,
    input  logic [31:0] status,
    input  logic [31:0] exc_addr,
    output logic        cp0_exception,
    output logic        cp0_eret,
    output logic [4:0]  cp0_cause,
    output logic        stall,
    output logic        pc_load,
    output logic [31:0] pc_next,
    output logic        timer_int,
    output logic        busy
);

    // Sequencer states
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT     = 2'd2;
    localparam logic [1:0] c_REDIRECT = 2'd3;

    // Cause codes handed to CP0
    localparam logic [4:0] c_CAUSE_INT = 5'd0;
    localparam logic [4:0] c_CAUSE_SYS = 5'd8;
    localparam logic [4:0] c_CAUSE_BRK = 5'd9;
    localparam logic [4:0] c_CAUSE_TEQ = 5'd13;

    logic [1:0]  r_state_q,    w_state_d;
    logic        r_is_eret_q,  w_is_eret_d;
    logic        r_is_int_q,   w_is_int_d;
    logic [4:0]  r_cause_q,    w_cause_d;
    logic [31:0] r_target_q,   w_target_d;
    logic        r_int_pend_q, w_int_pend_d;
    logic        r_tmr_pend_q, w_tmr_pend_d;

    logic        w_tmr_fire;
    logic        w_tmr_clr;
    logic        w_int_eligible;
    logic        w_unused_status;

    // Only the global interrupt enable bit of status matters here.
    assign w_unused_status = ^status[31:1];

    // An interrupt arriving in the boundary cycle itself is already eligible.
    assign w_int_eligible = (r_int_pend_q | intr | r_tmr_pend_q) & status[0];

`ifdef EXC_CTRL_TIMER_EN
    logic [31:0] r_tmr_cnt_q, w_tmr_cnt_d;

    // Free-running down-counter; expiry raises the timer pending bit.
    always_comb begin
        w_tmr_fire  = (r_tmr_cnt_q == 32'd0);
        w_tmr_cnt_d = w_tmr_fire ? (TIMER_PERIOD - 32'd1) : (r_tmr_cnt_q - 32'd1);
    end

    // Timer counter register, reloaded at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr_cnt_q <= TIMER_PERIOD - 32'd1;
        end else begin
            r_tmr_cnt_q <= w_tmr_cnt_d;
        end
    end
`else
    logic [31:0] w_unused_period;

    // No timer source in this build; the period is intentionally unused.
    assign w_unused_period = TIMER_PERIOD;
    assign w_tmr_fire      = 1'b0;
`endif

    // Next-state logic: arbitration in IDLE, then a fixed 3-cycle sequence.
    always_comb begin
        w_state_d    = r_state_q;
        w_is_eret_d  = r_is_eret_q;
        w_is_int_d   = r_is_int_q;
        w_cause_d    = r_cause_q;
        w_target_d   = r_target_q;
        w_int_pend_d = r_int_pend_q | intr;
        w_tmr_clr    = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                if (instr_boundary) begin
                    if (teq_req) begin
                        w_state_d   = c_ISSUE;
                        w_is_eret_d = 1'b0;
                        w_is_int_d  = 1'b0;
                        w_cause_d   = c_CAUSE_TEQ;
                    end else if (brk_req) begin
                        w_state_d   = c_ISSUE;
                        w_is_eret_d = 1'b0;
                        w_is_int_d  = 1'b0;
                        w_cause_d   = c_CAUSE_BRK;
                    end else if (sys_req) begin
                        w_state_d   = c_ISSUE;
                        w_is_eret_d = 1'b0;
                        w_is_int_d  = 1'b0;
                        w_cause_d   = c_CAUSE_SYS;
                    end else if (eret_req) begin
                        w_state_d   = c_ISSUE;
                        w_is_eret_d = 1'b1;
                        w_is_int_d  = 1'b0;
                        w_cause_d   = 5'd0;
                    end else if (w_int_eligible) begin
                        w_state_d   = c_ISSUE;
                        w_is_eret_d = 1'b0;
                        w_is_int_d  = 1'b1;
                        w_cause_d   = c_CAUSE_INT;
                    end
                end
            end
            c_ISSUE: begin
                // A still-asserted level interrupt remains pending.
                if (r_is_int_q) begin
                    w_int_pend_d = intr;
                    w_tmr_clr    = 1'b1;
                end
                w_state_d = c_WAIT;
            end
            c_WAIT: begin
                w_target_d = exc_addr;
                w_state_d  = c_REDIRECT;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase

        // A timer expiry in the clearing cycle is a new event and survives.
        w_tmr_pend_d = (r_tmr_pend_q & ~w_tmr_clr) | w_tmr_fire;
    end

    // State and pending registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_IDLE;
            r_is_eret_q  <= 1'b0;
            r_is_int_q   <= 1'b0;
            r_cause_q    <= 5'd0;
            r_target_q   <= 32'd0;
            r_int_pend_q <= 1'b0;
            r_tmr_pend_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_is_eret_q  <= w_is_eret_d;
            r_is_int_q   <= w_is_int_d;
            r_cause_q    <= w_cause_d;
            r_target_q   <= w_target_d;
            r_int_pend_q <= w_int_pend_d;
            r_tmr_pend_q <= w_tmr_pend_d;
        end
    end

    // Moore outputs decoded purely from registered state.
    always_comb begin
        cp0_exception = (r_state_q == c_ISSUE) & ~r_is_eret_q;
        cp0_eret      = (r_state_q == c_ISSUE) &  r_is_eret_q;
        cp0_cause     = cp0_exception ? r_cause_q : 5'd0;
        stall         = (r_state_q != c_IDLE);
        busy          = stall;
        pc_load       = (r_state_q == c_REDIRECT);
        pc_next       = pc_load ? r_target_q : 32'd0;
        timer_int     = r_tmr_pend_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Self-checking bench for exc_ctrl. A cycle-count model predicts
//               every output on each cycle; directed scenarios add literal
//               expectations at key cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    localparam int P = 10;
`ifdef EXC_CTRL_TIMER_EN
    localparam bit TMR_EN = 1'b1;
`else
    localparam bit TMR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_boundary = 1'b0;
    logic        sys_req = 1'b0, brk_req = 1'b0, teq_req = 1'b0, eret_req = 1'b0;
    logic        intr = 1'b0;
    logic [31:0] status = 32'd0;
    logic [31:0] exc_addr = 32'd0;
    logic        cp0_exception, cp0_eret, stall, pc_load, timer_int, busy;
    logic [4:0]  cp0_cause;
    logic [31:0] pc_next;

    int n_checks = 0;
    int n_errors = 0;

    exc_ctrl #(.TIMER_PERIOD(32'd10)) dut (
        .clk(clk), .rst(rst), .instr_boundary(instr_boundary),
        .sys_req(sys_req), .brk_req(brk_req), .teq_req(teq_req),
        .eret_req(eret_req), .intr(intr), .status(status), .exc_addr(exc_addr),
        .cp0_exception(cp0_exception), .cp0_eret(cp0_eret), .cp0_cause(cp0_cause),
        .stall(stall), .pc_load(pc_load), .pc_next(pc_next),
        .timer_int(timer_int), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = cycles since an accepted boundary (0 = idle, 1..3 = sequence).
    int          m_age = 0;
    bit          m_eret = 0, m_int = 0, m_int_pend = 0, m_tmr_pend = 0;
    logic [4:0]  m_cause = 0;
    logic [31:0] m_target = 0;
    int          m_clocks = 0;

    // Compare current outputs, then predict the effect of the coming edge.
    always @(negedge clk) begin
        chk("cp0_exception", {31'd0, cp0_exception}, {31'd0, (m_age == 1) && !m_eret});
        chk("cp0_eret",      {31'd0, cp0_eret},      {31'd0, (m_age == 1) && m_eret});
        chk("cp0_cause",     {27'd0, cp0_cause},     {27'd0, ((m_age == 1) && !m_eret) ? m_cause : 5'd0});
        chk("stall",         {31'd0, stall},         {31'd0, m_age != 0});
        chk("busy",          {31'd0, busy},          {31'd0, m_age != 0});
        chk("pc_load",       {31'd0, pc_load},       {31'd0, m_age == 3});
        chk("pc_next",       pc_next,                (m_age == 3) ? m_target : 32'd0);
        chk("timer_int",     {31'd0, timer_int},     {31'd0, m_tmr_pend});

        if (rst) begin
            m_age = 0; m_eret = 0; m_int = 0; m_int_pend = 0; m_tmr_pend = 0;
            m_cause = 0; m_target = 0; m_clocks = 0;
        end else begin
            bit new_int, new_tmr, fire;
            m_clocks = m_clocks + 1;
            fire     = TMR_EN && (m_clocks % P == 0);
            new_int  = m_int_pend | intr;
            new_tmr  = m_tmr_pend;
            case (m_age)
                0: if (instr_boundary) begin
                    m_age = 1; m_eret = 0; m_int = 0;
                    if (teq_req)       m_cause = 13;
                    else if (brk_req)  m_cause = 9;
                    else if (sys_req)  m_cause = 8;
                    else if (eret_req) begin m_eret = 1; m_cause = 0; end
                    else if ((m_int_pend | intr | m_tmr_pend) && status[0]) begin
                        m_int = 1; m_cause = 0;
                    end else m_age = 0;
                end
                1: begin
                    if (m_int) begin new_int = intr; new_tmr = 0; end
                    m_age = 2;
                end
                2: begin m_target = exc_addr; m_age = 3; end
                default: m_age = 0;
            endcase
            m_int_pend = new_int;
            m_tmr_pend = new_tmr | fire;
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a one-cycle boundary with requests {teq,brk,sys,eret}.
    task automatic bnd(input logic [3:0] r);
        instr_boundary = 1'b1;
        {teq_req, brk_req, sys_req, eret_req} = r;
        step();
        instr_boundary = 1'b0;
        {teq_req, brk_req, sys_req, eret_req} = 4'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset pc_next", pc_next, 32'd0);
        step();

        // Syscall with redirect to 0x4.
        exc_addr = 32'h4;
        bnd(4'b0010);
        @(negedge clk);
        chk("sys c1 exception", {31'd0, cp0_exception}, 32'd1);
        chk("sys c1 cause", {27'd0, cp0_cause}, 32'd8);
        chk("sys c1 stall", {31'd0, stall}, 32'd1);
        step(2);
        @(negedge clk);
        chk("sys c3 pc_load", {31'd0, pc_load}, 32'd1);
        chk("sys c3 pc_next", pc_next, 32'h4);
        step();
        @(negedge clk);
        chk("sys c4 stall", {31'd0, stall}, 32'd0);
        step();

        // Pending interrupt loses to teq, then is taken next boundary.
        status = 32'd1;
        intr = 1'b1; step(); intr = 1'b0;
        bnd(4'b1110);
        @(negedge clk);
        chk("teq cause", {27'd0, cp0_cause}, 32'd13);
        step(3);
        bnd(4'b0000);
        @(negedge clk);
        chk("int after teq cause", {27'd0, cp0_cause}, 32'd0);
        chk("int after teq exc", {31'd0, cp0_exception}, 32'd1);
        step(4);

        // eret.
        exc_addr = 32'h00400020;
        bnd(4'b0001);
        @(negedge clk);
        chk("eret c1 eret", {31'd0, cp0_eret}, 32'd1);
        chk("eret c1 exception", {31'd0, cp0_exception}, 32'd0);
        step(2);
        @(negedge clk);
        chk("eret c3 pc_next", pc_next, 32'h00400020);
        step(2);

        // Masked interrupt, then enabled.
        status = 32'd0;
        intr = 1'b1; step(); intr = 1'b0;
        bnd(4'b0000);
        @(negedge clk);
        chk("masked int stall", {31'd0, stall}, 32'd0);
        step();
        status = 32'd1;
        bnd(4'b0000);
        @(negedge clk);
        chk("unmasked int exc", {31'd0, cp0_exception}, 32'd1);
        step(3);
        bnd(4'b0000);
        @(negedge clk);
        chk("int cleared stall", {31'd0, stall}, 32'd0);
        step();

        // Reset in WAIT drops the sequence and the pending interrupt.
        bnd(4'b0010);
        intr = 1'b1; step(); intr = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst pc_load", {31'd0, pc_load}, 32'd0);
        step();
        bnd(4'b0000);
        @(negedge clk);
        chk("rst cleared pend", {31'd0, stall}, 32'd0);
        step();

        // intr mid-sequence stays pending; intr with boundary is eligible.
        bnd(4'b0100);
        step(); intr = 1'b1; step(); intr = 1'b0; step();
        bnd(4'b0000);
        @(negedge clk);
        chk("mid-seq int exc", {31'd0, cp0_exception}, 32'd1);
        step(4);
        intr = 1'b1;
        bnd(4'b0000);
        intr = 1'b0;
        @(negedge clk);
        chk("same-cycle int exc", {31'd0, cp0_exception}, 32'd1);
        step(4);

        // Timer source.
        if (TMR_EN) begin
            rst = 1'b1; step(); rst = 1'b0;
            step(9);
            @(negedge clk);
            chk("timer before", {31'd0, timer_int}, 32'd0);
            step();
            @(negedge clk);
            chk("timer rise", {31'd0, timer_int}, 32'd1);
            bnd(4'b0000);
            @(negedge clk);
            chk("timer cause", {27'd0, cp0_cause}, 32'd0);
            chk("timer exc", {31'd0, cp0_exception}, 32'd1);
            step();
            @(negedge clk);
            chk("timer cleared", {31'd0, timer_int}, 32'd0);
            step(3);
        end else begin
            step(12);
            @(negedge clk);
            chk("timer absent", {31'd0, timer_int}, 32'd0);
        end

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
